acc_display: RTL and testbench
==============================

ACC_DISPLAY -- requirements
Module: acc_display

Interface
REQ-001 Parameter WIDTH, default 14: width of signed input value; supported range 4..14.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 value_in  input  WIDTH  signed two's-complement accumulator result to display.
REQ-005 load  input  1  conversion request; sampled only when busy=0.
REQ-006 busy  output  1  high while a conversion is in progress.
REQ-007 valid  output  1  one-cycle pulse when new display patterns are latched.
REQ-008 hex0..hex3  output  7 each  digit segment patterns, hex0 = ones digit, bit order {g,f,e,d,c,b,a}, active-low.
REQ-009 hex_sign  output  7  sign position pattern, same encoding.

Function
REQ-010 The block SHALL have states IDLE, CONV and DONE; transitions IDLE->CONV on load&&!busy, CONV->DONE after WIDTH shift steps, DONE->IDLE unconditionally.
REQ-011 On acceptance at edge N the block SHALL capture sign = value_in[WIDTH-1] and magnitude = |value_in| as a WIDTH-bit unsigned value (most-negative input gives 2^(WIDTH-1) without overflow), clear the 16-bit BCD register and a step counter.
REQ-012 At each CONV edge (N+1..N+WIDTH) the block SHALL add 3 to every BCD nibble >= 5, then shift {BCD, magnitude} left by one.
REQ-013 At edge N+WIDTH+1 (DONE) the block SHALL latch hex0..hex3 and hex_sign, assert valid for exactly one cycle and deassert busy.
REQ-014 busy SHALL be 1 in the cycles following edges N..N+WIDTH and 0 otherwise; latency load-sample to valid = WIDTH+1 edges (15 for WIDTH=14).
REQ-015 load while busy=1, including the DONE cycle, SHALL be ignored with no queuing; value_in changes after acceptance SHALL NOT affect the result.
REQ-016 Display outputs SHALL hold their last latched values between conversions.
REQ-017 Digit patterns: 0=0x40 1=0x79 2=0x24 3=0x30 4=0x19 5=0x12 6=0x02 7=0x78 8=0x00 9=0x10; blank=0x7F; minus=0x3F.
REQ-018 hex_sign SHALL be minus when sign=1 and magnitude nonzero, blank otherwise.

Reset
REQ-019 reset SHALL return state to IDLE, busy=0, valid=0, clear counter and BCD register, and abort any conversion without emitting valid.
REQ-020 On reset hex0..hex3 SHALL show value 0 under the compiled blanking mode and hex_sign SHALL be blank.
REQ-021 reset SHALL take priority over load in the same cycle.

Configuration
REQ-022 Macro ACC_DISPLAY_ZERO_BLANK_EN defined: leading zero digits in hex3..hex1 SHALL show blank (0x7F); hex0 always shows its digit.
REQ-023 Macro undefined: all four digits SHALL show their decimal value including leading zeros (0x40).

Structure
REQ-024 A shared package/header SHALL hold segment constants (digit table, blank, minus), state encodings and BCD digit count (4).
REQ-025 Sub-module seg7_enc (4-bit BCD in, 7-bit active-low pattern out, purely combinational) SHALL be instantiated once per digit; blanking and sign logic stay in acc_display.

Verification
REQ-026 Reset -> busy=0, valid=0, hex_sign=0x7F, hex0=0x40, hex1..3=0x7F (macro) or 0x40 (no macro).
REQ-027 value_in=1234, load pulse -> valid exactly 15 edges later; hex3..0=0x79,0x24,0x30,0x19; hex_sign=0x7F.
REQ-028 value_in=-8192 -> hex3..0=0x00,0x79,0x10,0x24; hex_sign=0x3F.
REQ-029 value_in=7 -> hex0=0x78; hex1..3=0x7F with macro, 0x40 without.
REQ-030 load 5, then load 99 three cycles later while busy -> result shows 5, single valid; load 99 after valid -> shows 99.
REQ-031 reset asserted at 7th CONV cycle -> busy=0 after that edge, no valid pulse, displays at reset values; subsequent load of -1 -> hex0=0x79, hex_sign=0x3F.

Source files
------------

// File: rtl/acc_display_pkg.sv
// Shared constants for the accumulator display: segment table, FSM states, BCD sizing.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package acc_display_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int BCD_W      = 4 * BCD_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;

    // Entry i is the pattern for decimal digit i.
    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Double-dabble correction applied before each shift.
    function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/acc_display_seg7_enc.sv
// seg7_enc: one BCD digit to an active-low 7-segment pattern.
// Latency: combinational. Backpressure: none; codes above 9 show blank.
module seg7_enc
    import acc_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (bcd)
            4'd0: seg = SEG_DIGIT[0];
            4'd1: seg = SEG_DIGIT[1];
            4'd2: seg = SEG_DIGIT[2];
            4'd3: seg = SEG_DIGIT[3];
            4'd4: seg = SEG_DIGIT[4];
            4'd5: seg = SEG_DIGIT[5];
            4'd6: seg = SEG_DIGIT[6];
            4'd7: seg = SEG_DIGIT[7];
            4'd8: seg = SEG_DIGIT[8];
            4'd9: seg = SEG_DIGIT[9];
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/acc_display.sv
// acc_display: signed accumulator value to sign + 4 decimal 7-segment digits (double dabble).
// Latency: WIDTH+1 edges from accepted load to valid. Backpressure: load ignored while busy.
// ACC_DISPLAY_ZERO_BLANK_EN blanks leading zeros on hex3..hex1.
module acc_display
    import acc_display_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] value_in,
    input  logic                    load,
    output logic                    busy,
    output logic                    valid,
    output logic [6:0]              hex0,
    output logic [6:0]              hex1,
    output logic [6:0]              hex2,
    output logic [6:0]              hex3,
    output logic [6:0]              hex_sign
);

`ifdef ACC_DISPLAY_ZERO_BLANK_EN
    localparam bit ZERO_BLANK = 1'b1;
`else
    localparam bit ZERO_BLANK = 1'b0;
`endif

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [6:0] LEAD_ZERO = ZERO_BLANK ? SEG_BLANK : SEG_DIGIT[0];

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [BCD_W-1:0] bcd_q;
    logic [WIDTH-1:0] mag_q;
    logic             sign_q;

    logic [WIDTH-1:0] mag_init;
    logic [BCD_W-1:0] bcd_adj;
    logic [6:0]       seg [BCD_DIGITS];

    // Two's-complement negate as unsigned keeps the most-negative input exact.
    assign mag_init = value_in[WIDTH-1] ? (~value_in) + {{(WIDTH-1){1'b0}}, 1'b1}
                                        : value_in;
    assign bcd_adj  = bcd_add3(bcd_q);

    for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_enc
        seg7_enc u_enc (
            .bcd (bcd_q[4*i +: 4]),
            .seg (seg[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            valid    <= 1'b0;
            cnt      <= '0;
            bcd_q    <= '0;
            mag_q    <= '0;
            sign_q   <= 1'b0;
            hex0     <= SEG_DIGIT[0];
            hex1     <= LEAD_ZERO;
            hex2     <= LEAD_ZERO;
            hex3     <= LEAD_ZERO;
            hex_sign <= SEG_BLANK;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load && !busy) begin
                        sign_q <= value_in[WIDTH-1];
                        mag_q  <= mag_init;
                        bcd_q  <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    bcd_q <= {bcd_adj[BCD_W-2:0], mag_q[WIDTH-1]};
                    mag_q <= {mag_q[WIDTH-2:0], 1'b0};
                    cnt   <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    hex0     <= seg[0];
                    hex1     <= (ZERO_BLANK && bcd_q[BCD_W-1:4] == '0)  ? SEG_BLANK : seg[1];
                    hex2     <= (ZERO_BLANK && bcd_q[BCD_W-1:8] == '0)  ? SEG_BLANK : seg[2];
                    hex3     <= (ZERO_BLANK && bcd_q[BCD_W-1:12] == '0) ? SEG_BLANK : seg[3];
                    hex_sign <= (sign_q && bcd_q != '0) ? SEG_MINUS : SEG_BLANK;
                    valid    <= 1'b1;
                    busy     <= 1'b0;
                    state    <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_acc_display.sv
// Directed bench for acc_display at WIDTH=14 with hand-computed segment patterns.
module tb_acc_display;

    localparam int WIDTH = 14;

`ifdef ACC_DISPLAY_ZERO_BLANK_EN
    localparam logic [6:0] LZ = 7'h7F;
`else
    localparam logic [6:0] LZ = 7'h40;
`endif

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic signed [WIDTH-1:0] value_in = '0;
    logic                    load = 1'b0;
    logic                    busy;
    logic                    valid;
    logic [6:0]              hex0, hex1, hex2, hex3, hex_sign;

    int checks = 0;
    int failures = 0;

    acc_display #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .load     (load),
        .busy     (busy),
        .valid    (valid),
        .hex0     (hex0),
        .hex1     (hex1),
        .hex2     (hex2),
        .hex3     (hex3),
        .hex_sign (hex_sign)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic signed [WIDTH-1:0] v);
        value_in = v;
        load = 1'b1;
        tick();
        load = 1'b0;
        value_in = 14'sh1555;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (n < 40) begin
            tick();
            n++;
            if (valid) break;
        end
    endtask

    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (valid) nv++;
        end
    endtask

    initial begin
        int n;
        int nv;

        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_valid", valid, 0);
        chk("rst_sign", hex_sign, 7'h7F);
        chk("rst_hex0", hex0, 7'h40);
        chk("rst_hex1", hex1, LZ);
        chk("rst_hex3", hex3, LZ);

        do_load(14'sd1234);
        chk("1234_busy", busy, 1);
        wait_valid(n);
        chk("1234_latency", n, 15);
        chk("1234_busy_done", busy, 0);
        chk("1234_hex3", hex3, 7'h79);
        chk("1234_hex2", hex2, 7'h24);
        chk("1234_hex1", hex1, 7'h30);
        chk("1234_hex0", hex0, 7'h19);
        chk("1234_sign", hex_sign, 7'h7F);
        tick();
        chk("1234_valid_pulse", valid, 0);
        chk("1234_hold_hex0", hex0, 7'h19);

        do_load(-14'sd8192);
        wait_valid(n);
        chk("neg_latency", n, 15);
        chk("neg_hex3", hex3, 7'h00);
        chk("neg_hex2", hex2, 7'h79);
        chk("neg_hex1", hex1, 7'h10);
        chk("neg_hex0", hex0, 7'h24);
        chk("neg_sign", hex_sign, 7'h3F);

        do_load(14'sd7);
        wait_valid(n);
        chk("7_hex0", hex0, 7'h78);
        chk("7_hex1", hex1, LZ);
        chk("7_hex2", hex2, LZ);
        chk("7_hex3", hex3, LZ);
        chk("7_sign", hex_sign, 7'h7F);

        do_load(14'sd5);
        tick();
        tick();
        value_in = 14'sd99;
        load = 1'b1;
        tick();
        load = 1'b0;
        count_valid(30, nv);
        chk("busy_load_valids", nv, 1);
        chk("busy_load_hex0", hex0, 7'h12);
        chk("busy_load_hex1", hex1, LZ);

        do_load(14'sd99);
        wait_valid(n);
        chk("99_latency", n, 15);
        chk("99_hex0", hex0, 7'h10);
        chk("99_hex1", hex1, 7'h10);
        chk("99_hex2", hex2, LZ);

        do_load(14'sd1234);
        for (int i = 0; i < 6; i++) tick();
        chk("abort_busy_before", busy, 1);
        reset = 1'b1;
        tick();
        chk("abort_busy", busy, 0);
        chk("abort_valid", valid, 0);
        chk("abort_hex0", hex0, 7'h40);
        chk("abort_hex1", hex1, LZ);
        chk("abort_sign", hex_sign, 7'h7F);
        reset = 1'b0;
        count_valid(20, nv);
        chk("abort_no_valid", nv, 0);

        value_in = 14'sd42;
        load = 1'b1;
        reset = 1'b1;
        tick();
        chk("reset_prio_busy", busy, 0);
        reset = 1'b0;
        load = 1'b0;

        do_load(-14'sd1);
        wait_valid(n);
        chk("m1_latency", n, 15);
        chk("m1_hex0", hex0, 7'h79);
        chk("m1_hex1", hex1, LZ);
        chk("m1_sign", hex_sign, 7'h3F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
